// File: rtl/la_ibuf_filter.sv
// Pad-side input conditioner: resynchronises an asynchronous pad input into clk,
// rejects pulses shorter than FILTER cycles and emits rise/fall/glitch strobes.
module la_ibuf_filter #(
   parameter string PROP       = "DEFAULT",
   parameter int    SYNCSTAGES = 2,
   parameter int    FILTER     = 4,
   parameter logic  RSTVAL     = 1'b0
) (
   input  logic clk,
   input  logic nreset,
   input  logic in,
   input  logic filten,
   output logic z,
   output logic rise,
   output logic fall,
   output logic glitch
);

   localparam int CW = (FILTER > 1) ? $clog2(FILTER + 1) : 1;

   // PROP only tags the implementation for downstream flows; it has no logic.
   if (PROP == "") begin : g_prop_unset
   end

   logic [SYNCSTAGES-1:0] sync;
   logic                  s;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         thr;

   assign s   = sync[SYNCSTAGES-1];
   assign thr = filten ? CW'(FILTER - 1) : '0;

   // Plain flop chain so the synthesis flow can recognise it as a synchroniser.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync <= {SYNCSTAGES{RSTVAL}};
      end else begin
         sync <= {sync[SYNCSTAGES-2:0], in};
      end
   end

   // A new level is accepted only after s has disagreed with z for thr+1 edges;
   // falling back to agreement before that aborts the pending transition.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         z      <= RSTVAL;
         cnt    <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         glitch <= 1'b0;
      end else begin
         rise   <= 1'b0;
         fall   <= 1'b0;
         glitch <= 1'b0;
         if (s == z) begin
            if (cnt != '0) begin
               cnt    <= '0;
               glitch <= 1'b1;
            end
         end else if (cnt < thr) begin
            cnt <= cnt + 1'b1;
         end else begin
            z    <= s;
            cnt  <= '0;
            rise <= s;
            fall <= ~s;
         end
      end
   end

endmodule
